// File: rtl/shared_ram_arbiter_pkg.sv
// rtl/shared_ram_arbiter_pkg.sv - shared types and helpers for the RAM arbiter
package shared_ram_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Minimum result of 1 keeps single-entry fields legal vectors.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shared_ram_arbiter_if.sv
// rtl/shared_ram_arbiter_if.sv - channel request/response and RAM port bundle
interface shared_ram_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int CHANNEL = 5,
  parameter int ADDR_W  = 4
);
  logic [CHANNEL-1:0]        req_valid;
  logic [CHANNEL-1:0]        req_ready;
  logic [CHANNEL-1:0]        req_we;
  logic [CHANNEL*ADDR_W-1:0] req_addr;
  logic [CHANNEL*WIDTH-1:0]  req_wdata;
  logic [CHANNEL-1:0]        rsp_valid;
  logic [WIDTH-1:0]          rsp_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [WIDTH-1:0]          mem_wdata;
  logic [WIDTH-1:0]          mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/shared_ram_arbiter_rr_priority_picker.sv
// rtl/shared_ram_arbiter_rr_priority_picker.sv - combinational round-robin picker
module rr_priority_picker
  import shared_ram_arbiter_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  // Scan from ptr upward, wrapping modulo N; first set bit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        index = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// rtl/shared_ram_arbiter.sv - round-robin burst arbiter sharing one single-port RAM
module shared_ram_arbiter
  import shared_ram_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHANNEL   = 5,
  parameter int ADDR_W    = 4,
  parameter int MAX_BURST = 4,
  localparam int OW       = clog2(CHANNEL),
  localparam int BW       = clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  shared_ram_arbiter_if.slave bus,
  output logic [OW-1:0]       owner_id,
  output logic                busy
);

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   rr_ptr, rr_nxt;
  logic [BW-1:0]   burst_cnt, cnt_nxt;
  logic            rd_pend;
  logic [OW-1:0]   rsp_id;
  logic            hs;
  logic            rd_issue;
  logic            pick_found;
  logic [OW-1:0]   pick_idx;

  rr_priority_picker #(
    .N  (CHANNEL),
    .IW (OW)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rsp_id    <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= cnt_nxt;
      rd_pend   <= rd_issue;
      if (rd_issue) rsp_id <= owner;
    end
  end

  // Release on a dropped valid or on the handshake that completes the burst.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    cnt_nxt   = burst_cnt;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = OWN;
          owner_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      OWN: begin
        hs = bus.req_valid[owner];
        if (hs && burst_cnt != BW'(MAX_BURST)) cnt_nxt = burst_cnt + 1'b1;
        if (!hs || burst_cnt == BW'(MAX_BURST - 1)) begin
          state_nxt = IDLE;
          rr_nxt    = (owner == OW'(CHANNEL - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    rd_issue      = 1'b0;
    if (state == OWN) bus.req_ready = CHANNEL'(1) << owner;
    if (hs) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.req_we[owner];
      bus.mem_addr  = bus.req_addr[int'(owner) * ADDR_W +: ADDR_W];
      bus.mem_wdata = bus.req_wdata[int'(owner) * WIDTH +: WIDTH];
      rd_issue      = !bus.req_we[owner];
    end
  end

  // rsp_id was latched at issue, so the strobe follows the issuer, not the current owner.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (rd_pend) begin
      bus.rsp_valid = CHANNEL'(1) << rsp_id;
      bus.rsp_rdata = bus.mem_rdata;
    end
  end

  assign busy     = (state == OWN);
  assign owner_id = (state == OWN) ? owner : '0;

endmodule
